// File: rtl/codein_pkg.sv
// Shared definitions for the codein source-word unpacker: FSM encoding,
// datapath widths, descriptor-control bit positions and the encode byte swap.
package codein_pkg;

    localparam int HW_W       = 16;
    localparam int WORD_W     = 64;
    localparam int DC_W       = 24;
    localparam int DC_ENC_BIT = 5;
    localparam int DC_DEC_BIT = 6;
    localparam int CNT_W      = 2;

    localparam logic [CNT_W-1:0] CNT_FIRST = 2'd0;
    localparam logic [CNT_W-1:0] CNT_LAST  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Encoder consumes halfwords with their two bytes exchanged.
    function automatic logic [HW_W-1:0] byte_swap(input logic [HW_W-1:0] h);
        return {h[7:0], h[15:8]};
    endfunction

endpackage

// File: rtl/codein.sv
// codein: pops 64-bit words from a show-ahead source FIFO and feeds them,
// least-significant halfword first, to either the encoder or the decoder
// with a valid/ready handshake. A word flagged last ends the job (in_done).
module codein
    import codein_pkg::*;
(
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [DC_W-1:0]       dc,
    input  logic                  m_enable,
    input  logic [WORD_W-1:0]     m_src,
    input  logic                  m_src_empty,
    input  logic                  m_src_last,
    output logic                  m_src_getn,
    output logic [HW_W-1:0]       en_in_data,
    output logic [HW_W-1:0]       de_in_data,
    output logic                  en_in_valid,
    output logic                  de_in_valid,
    input  logic                  en_in_ready,
    input  logic                  de_in_ready,
    output logic                  en_in_last,
    output logic                  de_in_last,
    output logic                  in_done
);

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 getn_q, getn_d;
    logic                 done_q, done_d;

    logic                 sel_s;
    logic                 enc_s;
    logic                 ready_s;
    logic                 valid_s;
    logic                 hs_s;
    logic                 final_hw_s;
    logic [HW_W-1:0]      hw_s;
    logic [HW_W-1:0]      data_s;
    logic                 last_out_s;
    logic                 unused_dc_s;

    assign enc_s   = dc[DC_ENC_BIT];
    assign sel_s   = m_enable & (dc[DC_ENC_BIT] | dc[DC_DEC_BIT]);
    assign ready_s = enc_s ? en_in_ready : de_in_ready;

    // Descriptor bits outside the encode/decode selects belong to other blocks.
    assign unused_dc_s = ^{dc[DC_W-1:DC_DEC_BIT+1], dc[DC_ENC_BIT-1:0]};

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; everything holds while the port is not granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_s && !m_src_empty) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Leave only after the pop strobe was actually on the pin;
                // empty is deliberately not looked at, the pop is committed.
                if (sel_s && !getn_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (final_hw_s) begin
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: halfword select, encode swap, steering and last marker.
    always_comb begin
        valid_s = (state_q == ST_DRAIN) && sel_s;
        case (cnt_q)
            2'd0:    hw_s = word_q[15:0];
            2'd1:    hw_s = word_q[31:16];
            2'd2:    hw_s = word_q[47:32];
            2'd3:    hw_s = word_q[63:48];
            default: hw_s = word_q[15:0];
        endcase
        if (enc_s) begin
            data_s = byte_swap(hw_s);
        end else begin
            data_s = hw_s;
        end
        hs_s       = valid_s && ready_s;
        final_hw_s = hs_s && (cnt_q == CNT_LAST);
        last_out_s = valid_s && last_q && (cnt_q == CNT_LAST);
    end

    // Datapath next state: word capture on the pop edge, halfword counter.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if ((state_q == ST_FETCH) && (state_d == ST_DRAIN)) begin
            word_d = m_src;
            last_d = m_src_last;
            cnt_d  = CNT_FIRST;
        end else if (hs_s) begin
            cnt_d = cnt_q + 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
        // Strobe low for the single cycle the FSM sits in FETCH with the
        // grant present; a grant lost mid-FETCH re-arms it on resume.
        getn_d = !(sel_s && (state_d == ST_FETCH));
        done_d = done_q || (state_d == ST_DONE);
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q  <= CNT_FIRST;
            last_q <= 1'b0;
            getn_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            getn_q <= getn_d;
            done_q <= done_d;
        end
    end

    // Word buffer carries no reset; it is always loaded before being read.
    always_ff @(posedge wb_clk_i) begin
        word_q <= word_d;
    end

    assign m_src_getn  = sel_s ? getn_q : 1'bz;
    assign en_in_data  = data_s;
    assign de_in_data  = data_s;
    assign en_in_valid = valid_s & enc_s;
    assign de_in_valid = valid_s & ~enc_s;
    assign en_in_last  = last_out_s & enc_s;
    assign de_in_last  = last_out_s & ~enc_s;
    assign in_done     = done_q;

endmodule

// File: tb/tb_codein.sv
// Self-checking bench for codein: a source-FIFO model feeds random words,
// every pushed word queues its four expected halfwords, and a forked monitor
// pops and compares them on each observed handshake.
module tb_codein;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [23:0] dc;
    logic        m_enable;
    logic [63:0] m_src;
    logic        m_src_empty;
    logic        m_src_last;
    wire         m_src_getn;
    logic [15:0] en_in_data, de_in_data;
    logic        en_in_valid, de_in_valid;
    logic        en_in_ready, de_in_ready;
    logic        en_in_last, de_in_last;
    logic        in_done;

    codein dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .dc          (dc),
        .m_enable    (m_enable),
        .m_src       (m_src),
        .m_src_empty (m_src_empty),
        .m_src_last  (m_src_last),
        .m_src_getn  (m_src_getn),
        .en_in_data  (en_in_data),
        .de_in_data  (de_in_data),
        .en_in_valid (en_in_valid),
        .de_in_valid (de_in_valid),
        .en_in_ready (en_in_ready),
        .de_in_ready (de_in_ready),
        .en_in_last  (en_in_last),
        .de_in_last  (de_in_last),
        .in_done     (in_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } hw_t;

    hw_t         exp_q[$];
    logic [64:0] src_q[$];
    int          hs_cyc[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_count = 0;
    int          pop_cnt = 0;
    int          pops_applied = 0;
    int          cyc_n = 0;
    int          rmode = 0;
    logic        tog = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh_head();
        if (src_q.size() > 0) begin
            m_src       = src_q[0][63:0];
            m_src_last  = src_q[0][64];
            m_src_empty = 1'b0;
        end else begin
            m_src_last  = 1'b0;
            m_src_empty = 1'b1;
        end
    endtask

    // One clock: apply pops the monitor saw, update the FIFO head, new ready.
    task automatic cyc();
        logic r;
        logic o;
        logic [64:0] tmp;
        @(posedge wb_clk_i);
        #1;
        while (pops_applied < pop_cnt) begin
            if (src_q.size() > 0) begin
                tmp = src_q.pop_front();
            end
            pops_applied++;
        end
        refresh_head();
        tog = ~tog;
        case (rmode)
            0:       r = 1'b1;
            1:       r = tog;
            default: r = 1'($urandom_range(0, 1));
        endcase
        o = 1'($urandom_range(0, 1));
        if (dc[5]) begin
            en_in_ready = r;
            de_in_ready = o;
        end else begin
            en_in_ready = o;
            de_in_ready = r;
        end
    endtask

    function automatic logic cur_valid();
        return dc[5] ? en_in_valid : de_in_valid;
    endfunction

    // Monitor: runs on the falling edge, compares each handshake with the
    // scoreboard head and counts pops presented on the pin.
    task automatic monitor();
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data  = 16'h0;
        logic        sel, v, o, r, l;
        logic [15:0] d;
        hw_t         e;
        forever begin
            @(negedge wb_clk_i);
            cyc_n++;
            if (wb_rst_i) begin
                prev_stall = 1'b0;
            end else begin
                sel = m_enable & (dc[5] | dc[6]);
                v   = dc[5] ? en_in_valid : de_in_valid;
                o   = dc[5] ? de_in_valid : en_in_valid;
                r   = dc[5] ? en_in_ready : de_in_ready;
                d   = dc[5] ? en_in_data  : de_in_data;
                l   = dc[5] ? en_in_last  : de_in_last;
                if (prev_stall && sel) begin
                    chk("stall_valid_held", 64'(v), 64'd1);
                    chk("stall_data_stable", 64'(d), 64'(prev_data));
                end
                if (v && r) begin
                    chk("other_valid_low", 64'(o), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_halfword", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("hw_data", 64'(d), 64'(e.d));
                        chk("hw_last", 64'(l), 64'(e.l));
                    end
                    hs_count++;
                    hs_cyc.push_back(cyc_n);
                end
                prev_stall = v && !r && sel;
                prev_data  = d;
                if (sel && (m_src_getn === 1'b0)) begin
                    pop_cnt++;
                end
            end
        end
    endtask

    task automatic set_dc(input bit enc);
        logic [31:0] rnd;
        rnd   = $urandom;
        dc    = rnd[23:0];
        dc[5] = enc;
        dc[6] = enc ? rnd[6] : 1'b1;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        m_enable = 1'b1;
        exp_q.delete();
        src_q.delete();
        pops_applied = pop_cnt;
        refresh_head();
        cyc();
        chk("rst_en_valid", 64'(en_in_valid), 64'd0);
        chk("rst_de_valid", 64'(de_in_valid), 64'd0);
        chk("rst_last", 64'({en_in_last, de_in_last}), 64'd0);
        chk("rst_in_done", 64'(in_done), 64'd0);
        chk("rst_getn", 64'(m_src_getn), 64'd1);
        cyc();
        wb_rst_i = 1'b0;
    endtask

    task automatic job(input bit enc, input int nw, input int rm, input bit pause,
                       input bit rst_mid, input int idle_pre, input bit use_fixed,
                       input logic [63:0] fixed_w);
        int          base_pop, base_hs;
        bit          paused, rdone;
        logic [63:0] w;
        logic [15:0] h;
        hw_t         e;
        set_dc(enc);
        rmode = rm;
        do_reset();
        base_pop = pop_cnt;
        base_hs  = hs_count;
        paused   = 1'b0;
        rdone    = 1'b0;
        for (int t = 0; t < idle_pre; t++) begin
            cyc();
            chk("empty_no_valid", 64'(cur_valid()), 64'd0);
            chk("empty_getn_high", 64'(m_src_getn), 64'd1);
        end
        for (int i = 0; i < nw; i++) begin
            w = (use_fixed && i == 0) ? fixed_w : {$urandom, $urandom};
            src_q.push_back({(i == nw - 1) ? 1'b1 : 1'b0, w});
            for (int k = 0; k < 4; k++) begin
                h   = w[16*k +: 16];
                e.d = enc ? {h[7:0], h[15:8]} : h;
                e.l = (i == nw - 1) && (k == 3);
                exp_q.push_back(e);
            end
        end
        refresh_head();
        if (idle_pre > 0) begin
            cyc();
            chk("latency_cycle1_valid", 64'(cur_valid()), 64'd0);
            cyc();
            chk("latency_cycle2_valid", 64'(cur_valid()), 64'd1);
        end
        for (int t = 0; t < 400 && !(in_done && exp_q.size() == 0); t++) begin
            if (pause && !paused && (hs_count - base_hs == 2)) begin
                m_enable = 1'b0;
                repeat (5) cyc();
                chk("pause_no_hs", 64'(hs_count - base_hs), 64'd2);
                m_enable = 1'b1;
                paused   = 1'b1;
            end
            if (rst_mid && !rdone && (hs_count - base_hs == 2)) begin
                wb_rst_i = 1'b1;
                #1;
                chk("midrst_valid", 64'({en_in_valid, de_in_valid}), 64'd0);
                chk("midrst_last", 64'({en_in_last, de_in_last}), 64'd0);
                chk("midrst_in_done", 64'(in_done), 64'd0);
                cyc();
                cyc();
                repeat (2) e = exp_q.pop_front();
                wb_rst_i = 1'b0;
                rdone    = 1'b1;
            end
            cyc();
        end
        chk("job_in_done", 64'(in_done), 64'd1);
        chk("job_all_halfwords", 64'(exp_q.size()), 64'd0);
        chk("job_pop_count", 64'(pop_cnt - base_pop), 64'(nw));
        if (rm == 0 && nw == 1 && hs_cyc.size() >= base_hs + 4) begin
            chk("back_to_back", 64'(hs_cyc[base_hs + 3] - hs_cyc[base_hs]), 64'd3);
        end
        // After completion more source data must be left untouched.
        src_q.push_back({1'b0, $urandom, $urandom});
        refresh_head();
        base_pop = pop_cnt;
        repeat (5) cyc();
        chk("done_no_pop", 64'(pop_cnt - base_pop), 64'd0);
        chk("done_no_valid", 64'(cur_valid()), 64'd0);
        chk("done_sticky", 64'(in_done), 64'd1);
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        dc          = 24'h000040;
        m_enable    = 1'b1;
        m_src       = 64'h0;
        m_src_empty = 1'b1;
        m_src_last  = 1'b0;
        en_in_ready = 1'b0;
        de_in_ready = 1'b0;
        fork
            monitor();
        join_none

        job(1'b0, 1, 0, 1'b0, 1'b0, 0, 1'b1, 64'h4444_3333_2222_1111);
        job(1'b1, 1, 0, 1'b0, 1'b0, 0, 1'b1, 64'h0000_0000_0000_A1B2);
        job(1'b0, 3, 1, 1'b0, 1'b0, 0, 1'b0, 64'h0);
        job(1'b1, 2, 0, 1'b1, 1'b0, 0, 1'b0, 64'h0);
        job(1'b0, 3, 2, 1'b0, 1'b1, 0, 1'b0, 64'h0);
        job(1'b0, 1, 0, 1'b0, 1'b0, 10, 1'b0, 64'h0);
        for (int j = 0; j < 12; j++) begin
            job(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/codein.md
CODEIN -- requirements
Module: codein

Interface
REQ-001 wb_clk_i  input  1  system clock; all state changes on rising edge.
REQ-002 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-003 dc  input  24  descriptor control; dc[5]=1 encode, else decode; dc[6]=1 decode enable.
REQ-004 m_enable  input  1  memory-side port grant.
REQ-005 m_src  input  64  source word, show-ahead (head of source FIFO, valid while m_src_empty=0).
REQ-006 m_src_empty  input  1  active-high, no source word available.
REQ-007 m_src_last  input  1  head word is the final word of the job; qualified with m_src.
REQ-008 m_src_getn  output  1  active-low pop strobe; tri-state (z) when not selected.
REQ-009 en_in_data / de_in_data  output  16  halfword to encoder / decoder.
REQ-010 en_in_valid / de_in_valid  output  1  halfword valid, steered by dc[5].
REQ-011 en_in_ready / de_in_ready  input  1  consumer accepts the halfword this cycle.
REQ-012 en_in_last / de_in_last  output  1  marks the final halfword of the job.
REQ-013 in_done  output  1  sticky: final halfword accepted.

Function
REQ-014 sel = m_enable & (dc[5] | dc[6]); m_src_getn SHALL drive z when sel=0, otherwise the registered strobe.
REQ-015 FSM states: IDLE, FETCH, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE->FETCH when sel=1 and m_src_empty=0; m_src_getn_r registered low for exactly one cycle in FETCH.
REQ-017 On the edge ending FETCH, m_src is captured into a 64-bit buffer, m_src_last into last_r, cnt cleared to 0; FSM -> DRAIN.
REQ-018 In DRAIN, valid=1; halfword index cnt selects buf[15:0], [31:16], [47:32], [63:48] for cnt=0..3.
REQ-019 Encode (dc[5]=1): data = byte-swapped halfword {h[7:0],h[15:8]}; decode: data = h unchanged.
REQ-020 Data drives both en_in_data and de_in_data; en_in_valid = valid & dc[5]; de_in_valid = valid & ~dc[5].
REQ-021 ready = dc[5] ? en_in_ready : de_in_ready; handshake is valid & ready; cnt increments by 1 per handshake and wraps 3->0.
REQ-022 Data SHALL remain stable while valid=1 and ready=0.
REQ-023 *_in_last = valid & last_r & (cnt==3), steered like valid.
REQ-024 Handshake at cnt=3 with last_r=0: FSM -> IDLE, with one bubble cycle minimum before the next FETCH (no prefetch).
REQ-025 Handshake at cnt=3 with last_r=1: FSM -> DONE; in_done set next cycle, held until reset.
REQ-026 DONE: no further pops; valid=0; m_src_empty/m_src ignored.
REQ-027 sel dropping mid-operation: internal getn forced high, FSM and buffer hold; resume on sel=1.
REQ-028 m_src_empty=1 in IDLE: remain in IDLE, getn high.
REQ-029 m_src_empty SHALL NOT be sampled in FETCH; the pop is committed once FETCH is entered.
REQ-030 Latency: m_src_empty falling in IDLE -> first valid = 2 cycles.

Reset
REQ-031 Asynchronous reset: FSM=IDLE, cnt=0, last_r=0, in_done=0, m_src_getn_r=1, valid=0, all *_in_last=0; buffer is not reset.
REQ-032 Reset mid-DRAIN: the partially consumed word is discarded; no pop is issued until reset releases.

Structure
REQ-033 A shared package holds FSM state encodings, halfword width (16), word width (64), and dc bit indices (ENC=5, DEC=6).
REQ-034 Single module; no sub-module is required.

Verification
REQ-035 Decode, one word 0x4444_3333_2222_1111, last=1, ready=1: de_in_data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles; de_in_last on 0x4444; in_done set; one getn pulse.
REQ-036 Encode, word 0x0000_0000_0000_A1B2: first en_in_data=0xB2A1; de_in_valid stays 0 throughout.
REQ-037 Three words, last on the third, ready toggling 1/0: 12 halfwords in order; data stable during ready=0; exactly 3 getn pulses.
REQ-038 m_enable=0 in DRAIN for 5 cycles: m_src_getn=z; cnt frozen; resume completes with no loss or duplication.
REQ-039 wb_rst_i asserted at cnt=2: outputs at reset values immediately; new job after release starts at halfword 0 of the next word.
REQ-040 m_src_empty=1 for 10 cycles after reset: getn stays high, valid=0; first valid 2 cycles after empty falls.
